// File: rtl/ex_hilo_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ex_hilo_stage_pkg
// Description : ALU operation codes, HI/LO operation codes and decode helpers
//               shared by the EX/MEM HI/LO stage.
// Revision    : 1.0 - initial release
// ============================================================================
package ex_hilo_stage_pkg;

    localparam int ALUOP_W = 5;
    localparam int HILO_W  = 3;

    localparam logic [ALUOP_W-1:0] ALUOP_NOP   = 5'd0;
    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 5'd1;
    localparam logic [ALUOP_W-1:0] ALUOP_ADDU  = 5'd2;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 5'd3;
    localparam logic [ALUOP_W-1:0] ALUOP_SUBU  = 5'd4;
    localparam logic [ALUOP_W-1:0] ALUOP_AND   = 5'd5;
    localparam logic [ALUOP_W-1:0] ALUOP_OR    = 5'd6;
    localparam logic [ALUOP_W-1:0] ALUOP_XOR   = 5'd7;
    localparam logic [ALUOP_W-1:0] ALUOP_NOR   = 5'd8;
    localparam logic [ALUOP_W-1:0] ALUOP_SLT   = 5'd9;
    localparam logic [ALUOP_W-1:0] ALUOP_SLTU  = 5'd10;
    localparam logic [ALUOP_W-1:0] ALUOP_SLL   = 5'd11;
    localparam logic [ALUOP_W-1:0] ALUOP_SRL   = 5'd12;
    localparam logic [ALUOP_W-1:0] ALUOP_SRA   = 5'd13;
    localparam logic [ALUOP_W-1:0] ALUOP_LUI   = 5'd14;
    localparam logic [ALUOP_W-1:0] ALUOP_MULT  = 5'd15;
    localparam logic [ALUOP_W-1:0] ALUOP_MULTU = 5'd16;
    localparam logic [ALUOP_W-1:0] ALUOP_DIV   = 5'd17;
    localparam logic [ALUOP_W-1:0] ALUOP_DIVU  = 5'd18;

    localparam logic [HILO_W-1:0] HILO_NONE = 3'd0;
    localparam logic [HILO_W-1:0] HILO_MFHI = 3'd1;
    localparam logic [HILO_W-1:0] HILO_MFLO = 3'd2;
    localparam logic [HILO_W-1:0] HILO_MTHI = 3'd3;
    localparam logic [HILO_W-1:0] HILO_MTLO = 3'd4;

    // NOP and codes beyond the table carry no side effects at all.
    function automatic logic op_is_known(input logic [ALUOP_W-1:0] op);
        return (op != ALUOP_NOP) && (op <= ALUOP_DIVU);
    endfunction

    function automatic logic op_is_muldiv(input logic [ALUOP_W-1:0] op);
        return (op == ALUOP_MULT) || (op == ALUOP_MULTU) ||
               (op == ALUOP_DIV)  || (op == ALUOP_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_hilo_stage_hilo_reg.sv
`default_nettype none
// ============================================================================
// Module      : hilo_reg
// Description : Architectural HI/LO register pair with independent writes.
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_reg #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_hi,
    input  logic          we_lo,
    input  logic [DW-1:0] d_hi,
    input  logic [DW-1:0] d_lo,
    output logic [DW-1:0] hi_o,
    output logic [DW-1:0] lo_o
);

    logic [DW-1:0] r_hi;
    logic [DW-1:0] r_lo;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else begin
            if (we_hi) r_hi <= d_hi;
            if (we_lo) r_lo <= d_lo;
        end
    end

    assign hi_o = r_hi;
    assign lo_o = r_lo;

endmodule
`default_nettype wire

// File: rtl/ex_hilo_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_hilo_stage
// Description : EX/MEM pipeline register owning HI/LO; executes MFHI/MFLO/
//               MTHI/MTLO and commits MULT/DIV results, valid/ready + flush.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_hilo_stage
    import ex_hilo_stage_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [4:0]      aluop_i,
    input  logic [2*DW-1:0] aluout_i,
    input  logic            zero_i,
    input  logic [2:0]      hiloop_i,
    input  logic [RW-1:0]   rd_i,
    input  logic            wen_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [DW-1:0]   result_o,
    output logic            zero_o,
    output logic [RW-1:0]   rd_o,
    output logic            wen_o,
    output logic [DW-1:0]   hi_o,
    output logic [DW-1:0]   lo_o
);

    logic          r_valid;
    logic [DW-1:0] r_result;
    logic          r_zero;
    logic [RW-1:0] r_rd;
    logic          r_wen;

    logic          w_accept;
    logic          w_known;
    logic          w_muldiv;
    logic          w_we_hi;
    logic          w_we_lo;
    logic [DW-1:0] w_d_hi;
    logic [DW-1:0] w_result;
    logic          w_wen;

    assign in_ready_o = ~r_valid | out_ready_i;
    assign w_accept   = in_valid_i & in_ready_o & ~flush_i;

    assign w_known  = op_is_known(aluop_i);
    assign w_muldiv = w_known & op_is_muldiv(aluop_i);

    // HI/LO commit on the accept edge so a following MFHI/MFLO sees the new pair.
    assign w_we_hi = w_accept & w_known & (w_muldiv | (hiloop_i == HILO_MTHI));
    assign w_we_lo = w_accept & w_known & (w_muldiv | (hiloop_i == HILO_MTLO));
    assign w_d_hi  = w_muldiv ? aluout_i[2*DW-1:DW] : aluout_i[DW-1:0];

    always_comb begin
        w_result = aluout_i[DW-1:0];
        case (hiloop_i)
            HILO_MFHI: w_result = hi_o;
            HILO_MFLO: w_result = lo_o;
            default:   w_result = aluout_i[DW-1:0];
        endcase
    end

    assign w_wen = wen_i & w_known & ~w_muldiv;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_rd     <= '0;
            r_wen    <= 1'b0;
        end else if (flush_i) begin
            r_valid <= 1'b0;
            r_wen   <= 1'b0;
        end else if (w_accept) begin
            r_valid  <= 1'b1;
            r_result <= w_result;
            r_zero   <= zero_i;
            r_rd     <= rd_i;
            r_wen    <= w_wen;
        end else if (out_ready_i) begin
            r_valid <= 1'b0;
        end
    end

    hilo_reg #(
        .DW (DW)
    ) u_hilo_reg (
        .clk   (clk),
        .rst   (rst),
        .we_hi (w_we_hi),
        .we_lo (w_we_lo),
        .d_hi  (w_d_hi),
        .d_lo  (aluout_i[DW-1:0]),
        .hi_o  (hi_o),
        .lo_o  (lo_o)
    );

    assign out_valid_o = r_valid;
    assign result_o    = r_result;
    assign zero_o      = r_zero;
    assign rd_o        = r_rd;
    assign wen_o       = r_wen;

endmodule
`default_nettype wire

// File: tb/tb_ex_hilo_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_hilo_stage
// Description : Directed vector table plus hand sequences for stall, flush
//               and reset-during-stall on ex_hilo_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_hilo_stage;
    import ex_hilo_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [4:0]  aluop_i;
    logic [63:0] aluout_i;
    logic        zero_i;
    logic [2:0]  hiloop_i;
    logic [4:0]  rd_i;
    logic        wen_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] result_o;
    logic        zero_o;
    logic [4:0]  rd_o;
    logic        wen_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int checks   = 0;
    int failures = 0;

    always #10 clk = ~clk;

    ex_hilo_stage #(.DW(32), .RW(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .aluop_i     (aluop_i),
        .aluout_i    (aluout_i),
        .zero_i      (zero_i),
        .hiloop_i    (hiloop_i),
        .rd_i        (rd_i),
        .wen_i       (wen_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .zero_o      (zero_o),
        .rd_o        (rd_o),
        .wen_o       (wen_o),
        .hi_o        (hi_o),
        .lo_o        (lo_o)
    );

    typedef struct {
        logic [4:0]  aluop;
        logic [63:0] aluout;
        logic        zero;
        logic [2:0]  hiloop;
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] exp_result;
        logic        exp_zero;
        logic        exp_wen;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] op, input logic [63:0] aout,
                         input logic z, input logic [2:0] hop, input logic [4:0] rd, input logic we);
        in_valid_i = v;
        aluop_i    = op;
        aluout_i   = aout;
        zero_i     = z;
        hiloop_i   = hop;
        rd_i       = rd;
        wen_i      = we;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{ALUOP_MULT,  64'h00000002_FFFFFFFE, 1'b0, HILO_NONE, 5'd5,  1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 32'h2,    32'hFFFFFFFE};
        vecs[1] = '{ALUOP_ADD,   64'h0,                 1'b0, HILO_MFHI, 5'd4,  1'b1, 32'h2,        1'b0, 1'b1, 32'h2,    32'hFFFFFFFE};
        vecs[2] = '{ALUOP_ADD,   64'h0,                 1'b0, HILO_MFLO, 5'd6,  1'b1, 32'hFFFFFFFE, 1'b0, 1'b1, 32'h2,    32'hFFFFFFFE};
        vecs[3] = '{ALUOP_ADD,   64'h1234,              1'b0, HILO_MTHI, 5'd0,  1'b0, 32'h1234,     1'b0, 1'b0, 32'h1234, 32'hFFFFFFFE};
        vecs[4] = '{ALUOP_ADD,   64'h55,                1'b0, HILO_MTLO, 5'd0,  1'b0, 32'h55,       1'b0, 1'b0, 32'h1234, 32'h55};
        vecs[5] = '{ALUOP_DIVU,  64'h00000007_00000003, 1'b0, HILO_NONE, 5'd7,  1'b1, 32'h3,        1'b0, 1'b0, 32'h7,    32'h3};
        vecs[6] = '{ALUOP_SUB,   64'h0,                 1'b1, HILO_NONE, 5'd9,  1'b1, 32'h0,        1'b1, 1'b1, 32'h7,    32'h3};
        vecs[7] = '{ALUOP_NOP,   64'hDEAD,              1'b0, HILO_NONE, 5'd10, 1'b1, 32'hDEAD,     1'b0, 1'b0, 32'h7,    32'h3};
        vecs[8] = '{5'd31,       64'h99,                1'b0, HILO_MTHI, 5'd11, 1'b1, 32'h99,       1'b0, 1'b0, 32'h7,    32'h3};

        rst = 1'b1; flush_i = 1'b0; out_ready_i = 1'b1;
        drive(1'b0, ALUOP_NOP, 64'h0, 1'b0, HILO_NONE, 5'd0, 1'b0);
        step(); step();
        check("rst_valid",  {63'b0, out_valid_o}, 64'd0);
        check("rst_result", {32'b0, result_o},    64'd0);
        check("rst_zero",   {63'b0, zero_o},      64'd0);
        check("rst_rd",     {59'b0, rd_o},        64'd0);
        check("rst_wen",    {63'b0, wen_o},       64'd0);
        check("rst_hi",     {32'b0, hi_o},        64'd0);
        check("rst_lo",     {32'b0, lo_o},        64'd0);
        check("rst_ready",  {63'b0, in_ready_o},  64'd1);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            drive(1'b1, vecs[i].aluop, vecs[i].aluout, vecs[i].zero, vecs[i].hiloop, vecs[i].rd, vecs[i].wen);
            step();
            check($sformatf("v%0d_valid", i),  {63'b0, out_valid_o}, 64'd1);
            check($sformatf("v%0d_result", i), {32'b0, result_o},    {32'b0, vecs[i].exp_result});
            check($sformatf("v%0d_zero", i),   {63'b0, zero_o},      {63'b0, vecs[i].exp_zero});
            check($sformatf("v%0d_rd", i),     {59'b0, rd_o},        {59'b0, vecs[i].rd});
            check($sformatf("v%0d_wen", i),    {63'b0, wen_o},       {63'b0, vecs[i].exp_wen});
            check($sformatf("v%0d_hi", i),     {32'b0, hi_o},        {32'b0, vecs[i].exp_hi});
            check($sformatf("v%0d_lo", i),     {32'b0, lo_o},        {32'b0, vecs[i].exp_lo});
        end

        // Back-pressure: ADD captured, then downstream stalls for 3 cycles.
        drive(1'b1, ALUOP_ADD, 64'h5, 1'b0, HILO_NONE, 5'd3, 1'b1);
        step();
        out_ready_i = 1'b0;
        drive(1'b1, ALUOP_SUB, 64'h77, 1'b0, HILO_NONE, 5'd6, 1'b1);
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("stall%0d_ready", c),  {63'b0, in_ready_o},  64'd0);
            check($sformatf("stall%0d_valid", c),  {63'b0, out_valid_o}, 64'd1);
            check($sformatf("stall%0d_result", c), {32'b0, result_o},    64'h5);
            check($sformatf("stall%0d_rd", c),     {59'b0, rd_o},        64'd3);
            check($sformatf("stall%0d_wen", c),    {63'b0, wen_o},       64'd1);
        end
        out_ready_i = 1'b1;
        #1;
        check("unstall_ready", {63'b0, in_ready_o}, 64'd1);
        step();
        check("second_result", {32'b0, result_o}, 64'h77);
        check("second_rd",     {59'b0, rd_o},     64'd6);

        // MTHI then flushed DIV: HI from MTHI, DIV's HI/LO write discarded.
        drive(1'b1, ALUOP_ADD, 64'h1234, 1'b0, HILO_MTHI, 5'd0, 1'b0);
        step();
        check("mthi_hi", {32'b0, hi_o}, 64'h1234);
        drive(1'b1, ALUOP_DIV, 64'h1_0002, 1'b0, HILO_NONE, 5'd0, 1'b0);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        check("flush_valid", {63'b0, out_valid_o}, 64'd0);
        check("flush_wen",   {63'b0, wen_o},       64'd0);
        check("flush_hi",    {32'b0, hi_o},        64'h1234);
        check("flush_lo",    {32'b0, lo_o},        64'h3);
        drive(1'b0, ALUOP_NOP, 64'h0, 1'b0, HILO_NONE, 5'd0, 1'b0);
        step();
        check("idle_valid", {63'b0, out_valid_o}, 64'd0);

        // Reset asserted while the stage is stalled.
        drive(1'b1, ALUOP_ADD, 64'hAAAA, 1'b0, HILO_MTHI, 5'd0, 1'b0);
        step();
        out_ready_i = 1'b0;
        drive(1'b1, ALUOP_ADD, 64'h1, 1'b0, HILO_NONE, 5'd2, 1'b1);
        step();
        check("pre_rst_hi",    {32'b0, hi_o},        64'hAAAA);
        check("pre_rst_valid", {63'b0, out_valid_o}, 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_hi",     {32'b0, hi_o},        64'd0);
        check("mid_rst_lo",     {32'b0, lo_o},        64'd0);
        check("mid_rst_valid",  {63'b0, out_valid_o}, 64'd0);
        check("mid_rst_result", {32'b0, result_o},    64'd0);
        check("mid_rst_wen",    {63'b0, wen_o},       64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
